// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and one-shot transaction sequencer for the hyperbus controller.
// Detects controller errors and missing busy responses, then fences the bus until reset.
module hyperbus_arbiter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ISSUE_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic                 m0_reg,
  input  logic [31:0]          m0_adr,
  input  logic [2*WIDTH-1:0]   m0_dat,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic                 m1_reg,
  input  logic [31:0]          m1_adr,
  input  logic [2*WIDTH-1:0]   m1_dat,
  output logic                 m0_ack,
  output logic                 m0_err,
  output logic                 m0_rvalid,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic                 m1_rvalid,
  output logic [2*WIDTH-1:0]   rdat,
  output logic [31:0]          hb_adr,
  output logic [2*WIDTH-1:0]   hb_dat,
  output logic                 hb_reg,
  output logic                 hb_rrq,
  output logic                 hb_wrq,
  input  logic                 hb_busy,
  input  logic                 hb_dvalid,
  input  logic                 hb_error,
  input  logic [2*WIDTH-1:0]   hb_rdat,
  output logic                 fault
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = (ISSUE_TIMEOUT > 1) ? $clog2(ISSUE_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_DONE, S_FAULT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last, w_last_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_we, w_we_nxt;
  logic            r_reg, w_reg_nxt;
  logic [AW-1:0]   r_adr, w_adr_nxt;
  logic [DW-1:0]   r_dat, w_dat_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]      r_ack, w_ack_nxt;
  logic [1:0]      r_err, w_err_nxt;
  logic [1:0]      r_rvalid, w_rvalid_nxt;
  logic [DW-1:0]   r_rdat, w_rdat_nxt;
  logic            r_fault, w_fault_nxt;
  logic            w_to_fault;
  logic [1:0]      w_req;
  logic            w_gnt1;
  logic            w_rq_live;

  assign w_req  = {m1_req, m0_req};
  // Port 1 wins only when alone or when port 0 was served last.
  assign w_gnt1 = m1_req & (~m0_req | ~r_last);

  // State and all registered outputs/command fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_reg    <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_rvalid <= '0;
      r_rdat   <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_we     <= w_we_nxt;
      r_reg    <= w_reg_nxt;
      r_adr    <= w_adr_nxt;
      r_dat    <= w_dat_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdat   <= w_rdat_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_we_nxt     = r_we;
    w_reg_nxt    = r_reg;
    w_adr_nxt    = r_adr;
    w_dat_nxt    = r_dat;
    w_cnt_nxt    = r_cnt;
    w_ack_nxt    = '0;
    w_err_nxt    = '0;
    w_rvalid_nxt = '0;
    w_rdat_nxt   = r_rdat;
    w_fault_nxt  = r_fault;
    w_to_fault   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req != 2'b00) begin
          w_owner_nxt = w_gnt1;
          w_we_nxt    = w_gnt1 ? m1_we  : m0_we;
          w_reg_nxt   = w_gnt1 ? m1_reg : m0_reg;
          w_adr_nxt   = w_gnt1 ? m1_adr : m0_adr;
          w_dat_nxt   = w_gnt1 ? m1_dat : m0_dat;
          w_cnt_nxt   = CW'(ISSUE_TIMEOUT - 1);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hb_error) begin
          w_to_fault = 1'b1;
        end else if (hb_busy) begin
          w_state_nxt = S_ACTIVE;
        end else if (r_cnt == '0) begin
          w_to_fault = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_ACTIVE: begin
        if (hb_error) begin
          w_to_fault = 1'b1;
        end else begin
          if (hb_dvalid && !r_we) begin
            w_rdat_nxt            = hb_rdat;
            w_rvalid_nxt[r_owner] = 1'b1;
          end
          if (!hb_busy) begin
            w_ack_nxt[r_owner] = 1'b1;
            w_state_nxt        = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_last_nxt  = r_owner;
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        // Fenced: answer every held request with an error every other cycle.
        w_ack_nxt = w_req & ~r_ack;
        w_err_nxt = w_req & ~r_ack;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_to_fault) begin
      w_state_nxt        = S_FAULT;
      w_fault_nxt        = 1'b1;
      w_ack_nxt[r_owner] = 1'b1;
      w_err_nxt[r_owner] = 1'b1;
    end
  end

  // Request stays up in ACTIVE only while busy, so the controller cannot re-issue.
  assign w_rq_live = (r_state == S_ISSUE) | ((r_state == S_ACTIVE) & hb_busy);
  assign hb_rrq    = w_rq_live & ~r_we;
  assign hb_wrq    = w_rq_live & r_we;

  assign hb_adr    = r_adr;
  assign hb_dat    = r_dat;
  assign hb_reg    = r_reg;
  assign m0_ack    = r_ack[0];
  assign m1_ack    = r_ack[1];
  assign m0_err    = r_err[0];
  assign m1_err    = r_err[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign rdat      = r_rdat;
  assign fault     = r_fault;

endmodule
